// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the main_2 CPU fetch port.
// Accepts one fetch at a time and returns the word after WAIT_STATES
// wait cycles. A side load port writes program words at any time.
// Optional feature macro: FETCH_COUNT_EN (completed-response counter).
module instr_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [15:0]       fetch_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   cap_addr_c;
  logic                cap_in_range_c;
  logic [DATA_W-1:0]   cap_data_c;

  // Address range check shared by fetch and load paths
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Capture source: live request address when capturing on the accept edge
  always_comb begin
    cap_addr_c     = (state_q == S_IDLE) ? req_addr : addr_q;
    cap_in_range_c = in_range(cap_addr_c);
    cap_data_c     = '0;
    if (cap_in_range_c) begin
      cap_data_c = mem[IDX_W'(cap_addr_c)];
    end
  end

  // Program load port; array has no reset so contents survive reset
  always_ff @(posedge clock) begin
    if (load_en && in_range(load_addr)) begin
      mem[IDX_W'(load_addr)] <= load_data;
    end
  end

  // Fetch FSM with registered handshake and response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= cap_data_c;
              rsp_err   <= ~cap_in_range_c;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= cap_data_c;
            rsp_err   <= ~cap_in_range_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q   <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  // Saturating count of completed response handshakes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 16'h0000;
    end else if (rsp_valid && rsp_ready && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: default build (WAIT_STATES=1),
// a zero-wait DEPTH=128 instance and a WAIT_STATES=3 instance.
module tb_instr_mem_responder;

  logic        clock;
  logic        reset;

  // default-parameter instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
  logic [7:0]  req_addr, load_addr;
  logic [15:0] rsp_data, load_data, fetch_count;

  // DEPTH=128, WAIT_STATES=0 instance
  logic        req_valid_z, req_ready_z, rsp_valid_z, rsp_ready_z, rsp_err_z, load_en_z;
  logic [7:0]  req_addr_z, load_addr_z;
  logic [15:0] rsp_data_z, load_data_z, fetch_count_z;

  // WAIT_STATES=3 instance
  logic        req_valid_t, req_ready_t, rsp_valid_t, rsp_ready_t, rsp_err_t, load_en_t;
  logic [7:0]  req_addr_t, load_addr_t;
  logic [15:0] rsp_data_t, load_data_t, fetch_count_t;

  int checks;
  int failures;

`ifdef FETCH_COUNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  instr_mem_responder dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_count(fetch_count)
  );

  instr_mem_responder #(.DEPTH(128), .WAIT_STATES(0)) dut_z (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_addr(req_addr_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_data(rsp_data_z), .rsp_err(rsp_err_z),
    .load_en(load_en_z), .load_addr(load_addr_z), .load_data(load_data_z),
    .fetch_count(fetch_count_z)
  );

  instr_mem_responder #(.WAIT_STATES(3)) dut_t (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_t), .req_ready(req_ready_t), .req_addr(req_addr_t),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_data(rsp_data_t), .rsp_err(rsp_err_t),
    .load_en(load_en_t), .load_addr(load_addr_t), .load_data(load_data_t),
    .fetch_count(fetch_count_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fc_exp(input int n);
    return FC_ON ? 32'(n) : 32'h0;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    {req_valid, rsp_ready, load_en, req_addr, load_addr, load_data} = '0;
    {req_valid_z, rsp_ready_z, load_en_z, req_addr_z, load_addr_z, load_data_z} = '0;
    {req_valid_t, rsp_ready_t, load_en_t, req_addr_t, load_addr_t, load_data_t} = '0;

    // reset state
    repeat (2) tick();
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_fetch_count", 32'(fetch_count), 32'h0);
    reset = 1'b1;
    tick();

    // program words
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'hA5C3;
    tick();
    load_addr = 8'h05; load_data = 16'h0555;
    tick();
    load_en = 1'b0;

    // basic fetch: accept at T, valid visible after T+1, handshake at T+2
    req_valid = 1'b1; req_addr = 8'h10; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = 8'h05;
    check("f1_wait_valid", 32'(rsp_valid), 32'h0);
    check("f1_wait_ready", 32'(req_ready), 32'h0);
    tick();
    check("f1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("f1_rsp_data", 32'(rsp_data), 32'hA5C3);
    check("f1_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    check("f1_idle_valid", 32'(rsp_valid), 32'h0);
    check("f1_idle_ready", 32'(req_ready), 32'h1);

    // back-pressure with a rejected request held during the busy period
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'h05;
    tick();
    req_addr = 8'h10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_data", 32'(rsp_data), 32'h0555);
      check("bp_ready", 32'(req_ready), 32'h0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    check("bp_done_valid", 32'(rsp_valid), 32'h0);
    check("bp_done_ready", 32'(req_ready), 32'h1);
    tick();
    check("bp_single_hs", 32'(rsp_valid), 32'h0);

    // third completed fetch
    req_valid = 1'b1; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    tick();
    check("f3_rsp_data", 32'(rsp_data), 32'hA5C3);
    tick();
    check("fc_after_3", 32'(fetch_count), fc_exp(3));

    // async reset while a response is pending
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    tick();
    check("ar_pre_valid", 32'(rsp_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_valid_drop", 32'(rsp_valid), 32'h0);
    check("ar_ready_rise", 32'(req_ready), 32'h1);
    check("ar_fc_clear", 32'(fetch_count), 32'h0);
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) tick();
    check("ar_no_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 1'b1; req_addr = 8'h05;
    tick();
    req_valid = 1'b0;
    tick();
    check("ar_mem_kept_valid", 32'(rsp_valid), 32'h1);
    check("ar_mem_kept_data", 32'(rsp_data), 32'h0555);
    tick();
    check("fc_after_reset", 32'(fetch_count), fc_exp(1));

    // zero-wait instance, DEPTH=128
    load_en_z = 1'b1; load_addr_z = 8'h7F; load_data_z = 16'hBEEF;
    tick();
    load_addr_z = 8'h90; load_data_z = 16'hDEAD;
    tick();
    load_en_z = 1'b0;
    req_valid_z = 1'b1; req_addr_z = 8'h7F; rsp_ready_z = 1'b1;
    tick();
    req_valid_z = 1'b0;
    check("z_in_valid", 32'(rsp_valid_z), 32'h1);
    check("z_in_data", 32'(rsp_data_z), 32'hBEEF);
    check("z_in_err", 32'(rsp_err_z), 32'h0);
    tick();
    req_valid_z = 1'b1; req_addr_z = 8'h90;
    tick();
    req_valid_z = 1'b0;
    check("z_oor_valid", 32'(rsp_valid_z), 32'h1);
    check("z_oor_err", 32'(rsp_err_z), 32'h1);
    check("z_oor_data", 32'(rsp_data_z), 32'h0);
    tick();
    check("z_idle_valid", 32'(rsp_valid_z), 32'h0);
    check("z_idle_ready", 32'(req_ready_z), 32'h1);

    // WAIT_STATES=3: load in WAIT before capture is returned
    load_en_t = 1'b1; load_addr_t = 8'h20; load_data_t = 16'h1111;
    tick();
    load_en_t = 1'b0;
    req_valid_t = 1'b1; req_addr_t = 8'h20; rsp_ready_t = 1'b1;
    tick();
    req_valid_t = 1'b0;
    load_en_t = 1'b1; load_data_t = 16'h2222;
    tick();
    load_en_t = 1'b0;
    check("t_wait1_valid", 32'(rsp_valid_t), 32'h0);
    tick();
    check("t_wait2_valid", 32'(rsp_valid_t), 32'h0);
    tick();
    check("t_rsp_valid", 32'(rsp_valid_t), 32'h1);
    check("t_wait_load_data", 32'(rsp_data_t), 32'h2222);
    tick();
    check("t_idle_valid", 32'(rsp_valid_t), 32'h0);

    // load during RESP does not disturb the held word
    load_en_t = 1'b1; load_data_t = 16'h1111;
    tick();
    load_en_t = 1'b0;
    req_valid_t = 1'b1; rsp_ready_t = 1'b0;
    tick();
    req_valid_t = 1'b0;
    repeat (3) tick();
    check("t_resp_valid", 32'(rsp_valid_t), 32'h1);
    check("t_resp_data", 32'(rsp_data_t), 32'h1111);
    load_en_t = 1'b1; load_data_t = 16'h3333;
    tick();
    load_en_t = 1'b0;
    check("t_resp_load_held", 32'(rsp_data_t), 32'h1111);
    rsp_ready_t = 1'b1;
    tick();
    check("t_resp_done", 32'(rsp_valid_t), 32'h0);

    // load on the capture edge returns the old word
    req_valid_t = 1'b1;
    tick();
    req_valid_t = 1'b0;
    repeat (2) tick();
    load_en_t = 1'b1; load_data_t = 16'h4444;
    tick();
    load_en_t = 1'b0;
    check("t_cap_valid", 32'(rsp_valid_t), 32'h1);
    check("t_cap_old_data", 32'(rsp_data_t), 32'h3333);
    tick();
    req_valid_t = 1'b1;
    tick();
    req_valid_t = 1'b0;
    repeat (3) tick();
    check("t_cap_new_data", 32'(rsp_data_t), 32'h4444);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
